// File: rtl/mac_fp32_deconverter.sv
// FP32 -> MAC accumulator domain (biased exponent + signed integer), 2-stage valid/ready pipeline.
// Optional sticky status flags: define MAC_FP32_DECONV_FLAG_EN.
module mac_fp32_deconverter #(
    parameter int W_O_EXP        = 6,
    parameter int W_O_INT        = 34,
    parameter int MAC_W_DATATYPE = 3
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [MAC_W_DATATYPE-1:0] i_ifm_datatype,
    input  logic [MAC_W_DATATYPE-1:0] i_wfm_datatype,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [31:0]               i_data,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [W_O_EXP-1:0]        o_exp,
    output logic [W_O_INT-1:0]        o_intdata
`ifdef MAC_FP32_DECONV_FLAG_EN
    ,
    input  logic                      i_flag_clr,
    output logic [3:0]                o_flags
`endif
);

    localparam logic [MAC_W_DATATYPE-1:0] MAC_DT_I9   = MAC_W_DATATYPE'(1);
    localparam logic [MAC_W_DATATYPE-1:0] MAC_DT_FP8  = MAC_W_DATATYPE'(3);
    localparam logic [MAC_W_DATATYPE-1:0] MAC_DT_FP16 = MAC_W_DATATYPE'(4);

    localparam int                 EXP_MAX = (1 << W_O_EXP) - 1;
    localparam logic signed [9:0]  D_MAX   = 10'(EXP_MAX);
    localparam logic [W_O_EXP-1:0] EXP_SAT = '1;
    localparam logic [W_O_INT-1:0] INT_MAX = {1'b0, {(W_O_INT-1){1'b1}}};

    function automatic logic [9:0] bias_of(input logic [MAC_W_DATATYPE-1:0] dt);
        if (dt == MAC_DT_FP16) return 10'd15;
        if (dt == MAC_DT_FP8)  return 10'd7;
        return 10'd0;
    endfunction

    logic v0, v1, load0, load1;
    logic s0_sign, s0_zero, s0_inf, s0_nan;
    logic [7:0]  s0_e;
    logic [22:0] s0_m;
    logic [MAC_W_DATATYPE-1:0] s0_ifm, s0_wfm;

    assign load1   = !v1 || i_ready;
    assign load0   = !v0 || load1;
    assign o_ready = load0;
    assign o_valid = v1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            v0      <= 1'b0;
            s0_sign <= 1'b0;
            s0_e    <= '0;
            s0_m    <= '0;
            s0_zero <= 1'b0;
            s0_inf  <= 1'b0;
            s0_nan  <= 1'b0;
            s0_ifm  <= '0;
            s0_wfm  <= '0;
        end else if (load0) begin
            v0 <= i_valid;
            if (i_valid) begin
                s0_sign <= i_data[31];
                s0_e    <= i_data[30:23];
                s0_m    <= i_data[22:0];
                s0_zero <= (i_data[30:23] == 8'h00);
                s0_inf  <= (i_data[30:23] == 8'hFF) && (i_data[22:0] == '0);
                s0_nan  <= (i_data[30:23] == 8'hFF) && (i_data[22:0] != '0);
                s0_ifm  <= i_ifm_datatype;
                s0_wfm  <= i_wfm_datatype;
            end
        end
    end

    logic              is_i9, rup;
    logic [9:0]        bias_total;
    logic signed [9:0] d, nd;
    logic [23:0]       sig, rint;
    logic [7:0]        sh;
    logic [47:0]       rs;
    logic [W_O_INT-1:0] sig_fp, mag_c, int_c;
    logic [W_O_EXP-1:0] exp_c;

    always_comb begin
        is_i9      = (s0_ifm == MAC_DT_I9);
        bias_total = 10'd135 - bias_of(s0_ifm) - bias_of(s0_wfm);
        d          = $signed({2'b00, s0_e}) - $signed(bias_total);
        nd         = -d;
        sig        = {1'b1, s0_m};
        sig_fp     = {{(W_O_INT-24){1'b0}}, sig} << (W_O_INT-26);
        sh         = s0_e - 8'd150;
        // I9 fraction path: integer part in [47:24], guard at 23, sticky below
        rs         = {sig, 24'd0} >> (8'd150 - s0_e);
        rint       = rs[47:24];
        rup        = rs[23] && ((|rs[22:0]) || rint[0]);
        mag_c      = '0;
        exp_c      = '0;
        if (s0_zero) begin
            mag_c = '0;
        end else if (s0_nan || s0_inf) begin
            mag_c = INT_MAX;
            exp_c = is_i9 ? '0 : EXP_SAT;
        end else if (is_i9) begin
            if (s0_e < 8'd126)
                mag_c = '0;
            else if (s0_e >= 8'd150)
                mag_c = (sh >= 8'(W_O_INT-24)) ? INT_MAX
                                               : ({{(W_O_INT-24){1'b0}}, sig} << sh);
            else
                mag_c = W_O_INT'(rint) + W_O_INT'(rup);
        end else if (d < 10'sd0) begin
            mag_c = ($unsigned(nd) >= 10'(W_O_INT)) ? '0 : (sig_fp >> $unsigned(nd));
        end else if (d > D_MAX) begin
            mag_c = INT_MAX;
            exp_c = EXP_SAT;
        end else begin
            mag_c = sig_fp;
            exp_c = W_O_EXP'(d);
        end
        int_c = (s0_sign && !s0_nan) ? -mag_c : mag_c;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            v1        <= 1'b0;
            o_exp     <= '0;
            o_intdata <= '0;
        end else if (load1) begin
            v1 <= v0;
            if (v0) begin
                o_exp     <= exp_c;
                o_intdata <= int_c;
            end
        end
    end

`ifdef MAC_FP32_DECONV_FLAG_EN
    // A finite word saturates exactly when its magnitude lands on INT_MAX.
    logic [3:0] s1_flags, flags_c;

    always_comb begin
        flags_c[3] = s0_nan;
        flags_c[2] = s0_inf;
        flags_c[1] = !s0_nan && !s0_inf && (mag_c == INT_MAX);
        flags_c[0] = !s0_nan && !s0_inf && (mag_c == '0);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_flags <= '0;
            o_flags  <= '0;
        end else begin
            if (load1 && v0)
                s1_flags <= flags_c;
            if (i_flag_clr)
                o_flags <= '0;
            else if (v1 && i_ready)
                o_flags <= o_flags | s1_flags;
        end
    end
`endif

endmodule

// File: tb/tb_mac_fp32_deconverter.sv
// Self-checking bench for mac_fp32_deconverter: directed vectors plus randomized stream vs a real-arithmetic model.
module tb_mac_fp32_deconverter;

    localparam logic [2:0] DT_OTH  = 3'd0;
    localparam logic [2:0] DT_I9   = 3'd1;
    localparam logic [2:0] DT_FP8  = 3'd3;
    localparam logic [2:0] DT_FP16 = 3'd4;
    localparam longint MAXV = (longint'(1) << 33) - 1;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [2:0]  i_ifm_datatype, i_wfm_datatype;
    logic        i_valid, o_ready, o_valid, i_ready;
    logic [31:0] i_data;
    logic [5:0]  o_exp;
    logic [33:0] o_intdata;

    mac_fp32_deconverter dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_ifm_datatype (i_ifm_datatype),
        .i_wfm_datatype (i_wfm_datatype),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_data         (i_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_exp          (o_exp),
        .o_intdata      (o_intdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  ifm, wfm;
        bit          use_k;
        logic [5:0]  kexp;
        logic [33:0] kint;
    } item_t;

    typedef struct {
        logic [5:0]  e;
        logic [33:0] i;
    } res_t;

    item_t in_q[$];
    res_t  exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic real pow2(input int k);
        real r = 1.0;
        if (k >= 0) for (int j = 0; j < k; j++) r = r * 2.0;
        else        for (int j = 0; j < -k; j++) r = r / 2.0;
        return r;
    endfunction

    function automatic int bias_of(input logic [2:0] dt);
        if (dt == DT_FP16) return 15;
        if (dt == DT_FP8)  return 7;
        return 0;
    endfunction

    // Value semantics: o_intdata * 2^o_exp is the word scaled into the accumulator domain.
    function automatic res_t ref_model(input logic [31:0] w, input logic [2:0] ifm, input logic [2:0] wfm);
        res_t   r;
        int     e  = int'(w[30:23]);
        bit     s  = w[31];
        bit     i9 = (ifm == DT_I9);
        real    sig = real'(int'(w[22:0])) + 8388608.0;
        real    x, fl, fr;
        longint mi = 0;
        int     d;
        r.e = '0;
        r.i = '0;
        if (e == 0) return r;
        if (e == 255) begin
            r.e = i9 ? 6'd0 : 6'd63;
            r.i = (w[22:0] == 0 && s) ? 34'(-MAXV) : 34'(MAXV);
            return r;
        end
        if (i9) begin
            if (e - 127 >= -1) begin
                x  = sig * pow2(e - 150);
                fl = $floor(x);
                fr = x - fl;
                if (fl >= pow2(33)) mi = MAXV;
                else begin
                    mi = longint'(fl);
                    if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
                    if (mi > MAXV) mi = MAXV;
                end
            end
        end else begin
            d = e - (135 - bias_of(ifm) - bias_of(wfm));
            if (d > 63) begin
                r.e = 6'd63;
                mi  = MAXV;
            end else begin
                r.e = (d < 0) ? 6'd0 : 6'(d);
                mi  = longint'($floor(sig * pow2(8 + ((d < 0) ? d : 0))));
            end
        end
        r.i = 34'(s ? -mi : mi);
        return r;
    endfunction

    task automatic push_k(input logic [31:0] d, input logic [2:0] ifm, input logic [2:0] wfm,
                          input logic [5:0] ke, input logic [33:0] ki);
        item_t it;
        it.d = d; it.ifm = ifm; it.wfm = wfm; it.use_k = 1'b1; it.kexp = ke; it.kint = ki;
        in_q.push_back(it);
    endtask

    task automatic push_rand();
        item_t it;
        int    kind = $urandom_range(0, 9);
        logic [2:0] dts[4];
        dts[0] = DT_OTH; dts[1] = DT_I9; dts[2] = DT_FP8; dts[3] = DT_FP16;
        it.ifm = dts[$urandom_range(0, 3)];
        it.wfm = dts[$urandom_range(0, 3)];
        it.d   = $urandom;
        if (kind == 0)      it.d[30:23] = 8'h00;
        else if (kind == 1) it.d[30:23] = 8'hFF;
        else if (kind == 2) it.d[22:0]  = ($urandom_range(0, 1) == 1) ? 23'h0 : 23'h400000;
        if (kind >= 2 && kind <= 8) it.d[30:23] = 8'($urandom_range(90, 175));
        it.use_k = 1'b0; it.kexp = '0; it.kint = '0;
        in_q.push_back(it);
    endtask

    // One cycle starting at a negedge: drive, check output against the scoreboard, record accepts.
    task automatic drive_cycle(input bit rdy, input bit gaps);
        item_t it;
        res_t  r;
        bit    go;
        i_ready = rdy;
        go = (in_q.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
        if (go) begin
            it = in_q[0];
            i_valid = 1'b1; i_data = it.d; i_ifm_datatype = it.ifm; i_wfm_datatype = it.wfm;
        end else begin
            i_valid = 1'b0;
        end
        #1;
        if (o_valid) begin
            if (exp_q.size() == 0) chk("spurious_out", 64'(o_valid), 64'd0);
            else begin
                chk("o_exp", 64'(o_exp), 64'(exp_q[0].e));
                chk("o_intdata", 64'(o_intdata), 64'(exp_q[0].i));
                if (i_ready) void'(exp_q.pop_front());
            end
        end
        if (go && o_ready) begin
            if (it.use_k) begin r.e = it.kexp; r.i = it.kint; end
            else r = ref_model(it.d, it.ifm, it.wfm);
            exp_q.push_back(r);
            void'(in_q.pop_front());
        end
        @(negedge i_clk);
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && used < budget) begin
            drive_cycle(1'b1, 1'b0);
            used++;
        end
        if (in_q.size() > 0 || exp_q.size() > 0)
            chk("drain_timeout", 64'(in_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        int used;
        i_rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
        i_ifm_datatype = DT_FP16; i_wfm_datatype = DT_FP16;

        repeat (2) @(negedge i_clk);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_exp", 64'(o_exp), 64'd0);
        chk("rst_o_intdata", 64'(o_intdata), 64'd0);
        i_rstn = 1'b1;
        @(negedge i_clk);
        chk("rst_o_ready", 64'(o_ready), 64'd1);

        // Latency: accepted word appears exactly two cycles later
        i_ready = 1'b1; i_valid = 1'b1; i_data = 32'h3F800000;
        i_ifm_datatype = DT_FP16; i_wfm_datatype = DT_FP16;
        #1 chk("lat_accept", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("lat_cycle1", 64'(o_valid), 64'd0);
        @(negedge i_clk);
        chk("lat_cycle2", 64'(o_valid), 64'd1);
        chk("lat_exp", 64'(o_exp), 64'd22);
        chk("lat_int", 64'(o_intdata), 64'h0_8000_0000);
        @(negedge i_clk);
        chk("lat_single", 64'(o_valid), 64'd0);

        // Directed values at full throughput
        push_k(32'h3F800000, DT_FP16, DT_FP16, 6'd22, 34'h0_8000_0000);
        push_k(32'hBFC00000, DT_FP16, DT_FP16, 6'd22, 34'h3_4000_0000);
        push_k(32'h40200000, DT_I9,   DT_I9,   6'd0,  34'd2);
        push_k(32'h40600000, DT_I9,   DT_I9,   6'd0,  34'd4);
        push_k(32'hC0200000, DT_I9,   DT_I9,   6'd0,  34'h3_FFFF_FFFE);
        push_k(32'h3E800000, DT_I9,   DT_I9,   6'd0,  34'd0);
        push_k(32'h7F800000, DT_FP16, DT_FP16, 6'd63, 34'h1_FFFF_FFFF);
        push_k(32'h00000001, DT_FP16, DT_FP16, 6'd0,  34'd0);
        push_k(32'h3F000000, DT_I9,   DT_I9,   6'd0,  34'd0);
        push_k(32'h5F000000, DT_I9,   DT_I9,   6'd0,  34'h1_FFFF_FFFF);
        push_k(32'hFFC00000, DT_FP8,  DT_FP8,  6'd63, 34'h1_FFFF_FFFF);
        drain(40, used);
        chk("directed_rate", 64'(used), 64'd13);

        // Back-pressure: four words, downstream stalled for five cycles
        for (int k = 0; k < 4; k++) push_rand();
        repeat (5) drive_cycle(1'b0, 1'b0);
        chk("bp_o_ready", 64'(o_ready), 64'd0);
        chk("bp_o_valid", 64'(o_valid), 64'd1);
        chk("bp_accepted", 64'(exp_q.size()), 64'd2);
        drain(20, used);
        chk("bp_resume_rate", 64'(used), 64'd4);

        // Randomized stream with input gaps and random back-pressure
        for (int k = 0; k < 400; k++) begin
            if (in_q.size() < 4) push_rand();
            drive_cycle($urandom_range(0, 9) < 7, 1'b1);
        end
        drain(100, used);

        // Asynchronous reset mid-stream
        for (int k = 0; k < 4; k++) push_rand();
        repeat (2) drive_cycle(1'b1, 1'b0);
        chk("pre_rst_valid", 64'(o_valid), 64'd1);
        #2 i_rstn = 1'b0;
        #1;
        chk("async_rst_valid", 64'(o_valid), 64'd0);
        chk("async_rst_exp", 64'(o_exp), 64'd0);
        chk("async_rst_int", 64'(o_intdata), 64'd0);
        in_q.delete();
        exp_q.delete();
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        #1 chk("post_rst_ready", 64'(o_ready), 64'd1);
        @(negedge i_clk);
        repeat (3) drive_cycle(1'b1, 1'b0);
        chk("post_rst_idle", 64'(o_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
